icache_direct: RTL and testbench
================================

Name: icache_direct

Overview:
- Direct-mapped, single-word-block instruction cache between the datapath fetch stage and the memory controller's instruction port.
- Upstream, it consumes the datapath's instruction request (imemREN, imemaddr, halt) and returns ihit and imemload.
- Downstream, it issues iREN and iaddr and waits on iwait and iload.
- Hits return in the same cycle. Misses block until memory returns the word.

Parameters:
- NFRAMES, 16, number of cache frames; must be a power of two.
- IDX_W, 4, index width; equals log2(NFRAMES).
- TAG_W, 26, tag width; equals 32 - IDX_W - 2.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- RST  in  1  asynchronous active-high reset.
- halt  in  1  datapath halted; suppresses hits and new fills.
- imemREN  in  1  datapath instruction read request.
- imemaddr  in  32  byte address of the instruction; bits [1:0] are ignored.
- ihit  out  1  requested word is valid this cycle.
- imemload  out  32  instruction word; 0 when ihit=0.
- iwait  in  1  memory busy; 0 means iload is valid this cycle.
- iload  in  32  word returned by memory.
- iREN  out  1  memory read request.
- iaddr  out  32  word-aligned memory read address.
- miss_count  out  32  number of completed fills; saturates at 0xFFFFFFFF.

Behaviour:
- Address split: tag = imemaddr[31:IDX_W+2], idx = imemaddr[IDX_W+1:2].
- Storage per frame: valid bit, TAG_W-bit tag, 32-bit data word.
- Reset (asynchronous, takes effect immediately):
  - all valid bits cleared; state goes to IDLE.
  - miss_addr=0 and miss_count=0.
  - ihit=0, imemload=0, iREN=0, iaddr=0.
- Hit (combinational):
  - hit = imemREN & ~halt & valid[idx] & (tag_arr[idx]==tag) & (state==IDLE).
  - When hit=1: ihit=1 and imemload=data_arr[idx].
  - Otherwise ihit=0 and imemload=0.
- FSM states: IDLE, FETCH.
- IDLE:
  - iREN=0 and iaddr=0.
  - If imemREN & ~halt & ~hit: latch miss_addr={imemaddr[31:2],2'b00}, then go to FETCH on the next edge.
- FETCH:
  - iREN=1 and iaddr=miss_addr; ihit=0.
  - While iwait=1: hold in FETCH.
  - On the edge where iwait=0:
    - write data_arr[miss_addr idx]=iload, set its tag and valid=1.
    - increment miss_count unless it is already 0xFFFFFFFF.
    - return to IDLE.
- Miss latency:
  - miss detected in cycle 0; iREN asserted from cycle 1.
  - if iwait first goes 0 in cycle N, ihit=1 in cycle N+1 (provided the request is unchanged).
- Fills are never aborted:
  - If imemREN drops, imemaddr changes, or halt rises during FETCH, the fill still completes to miss_addr.
  - The new request is re-evaluated in IDLE afterwards.
- Conflict miss: a fill to an index holding a different tag overwrites that frame; there is no write-back.
- halt=1 in IDLE: ihit=0, no fill started, contents retained.
- Reset asserted mid-FETCH: iREN drops immediately and the partial fill is discarded; the frame is not written.
- The cache holds no dirty state and never writes memory.

Test Plan:
- Reset, then imemREN=1, imemaddr=0x00000040 -> ihit=0 in the first cycle; next cycle iREN=1, iaddr=0x00000040; with iwait=1 for 3 cycles then 0 and iload=0x8C220004 -> one cycle later ihit=1, imemload=0x8C220004, miss_count=1.
- After that fill, request 0x00000042 (misaligned) -> same-cycle ihit=1, imemload=0x8C220004, no iREN.
- Conflict: fill 0x00000040, then request 0x00000440 (same idx 0, different tag) -> miss, iaddr=0x00000440, fill with 0x12345678; re-request 0x00000040 -> miss again; miss_count=3.
- Change imemaddr to 0x00000080 while in FETCH for 0x00000040 -> fill completes to 0x00000040; the next cycle misses on 0x00000080 with iaddr=0x00000080.
- halt=1 with imemREN=1 on a cached address -> ihit=0, imemload=0, iREN=0 for all halted cycles; after halt=0, ihit returns the same cycle.
- Assert RST during FETCH (iwait=1) -> iREN=0 immediately; after release, the same address misses again and miss_count is 0 before the refill.

Source files
------------

// File: rtl/icache_direct.sv
// ---------------------------------------------------------------------------
// icache_direct
//   Direct-mapped instruction cache with single-word blocks. It sits between
//   the datapath fetch stage and the memory controller's instruction port.
//   A hit returns the word in the same cycle. A miss blocks in FETCH until
//   memory delivers the word, and the fill always completes once it starts.
//
// Ports
//   CLK, RST     clock; asynchronous active-high reset
//   halt         datapath halted: no hits and no new fills
//   imemREN      instruction read request from the datapath
//   imemaddr     byte address of the request (bits [1:0] ignored)
//   ihit         requested word valid this cycle
//   imemload     instruction word (0 when ihit=0)
//   iwait        memory busy; 0 means iload is valid this cycle
//   iload        word returned by memory
//   iREN, iaddr  memory read request and word-aligned address
//   miss_count   number of completed fills, saturating
// ---------------------------------------------------------------------------
module icache_direct #(
    parameter int NFRAMES = 16,
    parameter int IDX_W   = 4,
    parameter int TAG_W   = 26
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        halt,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    input  logic        iwait,
    input  logic [31:0] iload,
    output logic        iREN,
    output logic [31:0] iaddr,
    output logic [31:0] miss_count
);

    typedef enum logic {IDLE, FETCH} state_t;

    state_t             state_q, state_d;
    logic [NFRAMES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_arr_q  [NFRAMES];
    logic [31:0]        data_arr_q [NFRAMES];
    logic [31:0]        miss_addr_q, miss_addr_d;
    logic [31:0]        miss_count_q;

    logic [TAG_W-1:0]   req_tag, fill_tag;
    logic [IDX_W-1:0]   req_idx, fill_idx;
    logic               hit;
    logic               fill_done;
    logic               unused_byte_offset;

    assign req_tag  = imemaddr[31:IDX_W+2];
    assign req_idx  = imemaddr[IDX_W+1:2];
    assign fill_tag = miss_addr_q[31:IDX_W+2];
    assign fill_idx = miss_addr_q[IDX_W+1:2];

    // Instructions are word-aligned, so the byte offset is never looked at.
    assign unused_byte_offset = ^imemaddr[1:0];

    // A hit is only reported from IDLE, so nothing is served while a fill
    // is in progress, even if the frame being looked up is unrelated.
    assign hit = imemREN & ~halt & valid_q[req_idx]
               & (tag_arr_q[req_idx] == req_tag) & (state_q == IDLE);

    assign ihit     = hit;
    assign imemload = hit ? data_arr_q[req_idx] : 32'd0;

    // The fill commits on the edge where memory stops waiting.
    assign fill_done = (state_q == FETCH) & ~iwait;

    // NOTE: every signal driven here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        miss_addr_d = miss_addr_q;
        iREN        = 1'b0;
        iaddr       = 32'd0;
        case (state_q)
            IDLE: begin
                if (imemREN && !halt && !hit) begin
                    miss_addr_d = {imemaddr[31:2], 2'b00};
                    state_d     = FETCH;
                end
            end
            FETCH: begin
                // Request changes and halt are ignored here. The fill always
                // finishes, and the new request is looked at again in IDLE.
                iREN  = 1'b1;
                iaddr = miss_addr_q;
                if (!iwait) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values no matter how the processes are ordered.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= IDLE;
            miss_addr_q  <= 32'd0;
            miss_count_q <= 32'd0;
            valid_q      <= '0;
        end else begin
            state_q     <= state_d;
            miss_addr_q <= miss_addr_d;
            if (fill_done) begin
                valid_q[fill_idx] <= 1'b1;
                if (miss_count_q != 32'hFFFF_FFFF) begin
                    miss_count_q <= miss_count_q + 32'd1;
                end
            end
        end
    end

    // NOTE: the tag and data arrays are deliberately not reset. The valid
    // bits gate every use of them, so clearing them would add no value. A
    // reset during FETCH forces state_q to IDLE, so no partial fill is written.
    always_ff @(posedge CLK) begin
        if (fill_done) begin
            tag_arr_q[fill_idx]  <= fill_tag;
            data_arr_q[fill_idx] <= iload;
        end
    end

    assign miss_count = miss_count_q;

endmodule

// File: tb/tb_icache_direct.sv
// ---------------------------------------------------------------------------
// tb_icache_direct
//   Directed bench for icache_direct. Stimulus queues the expected hit data
//   and memory request addresses. Two monitors pop those queues when the DUT
//   presents ihit or starts an iREN request. Cycle-specific values such as
//   reset state, halt, and miss_count are checked inline.
// ---------------------------------------------------------------------------
module tb_icache_direct;

    logic        CLK = 1'b0;
    logic        RST;
    logic        halt;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        iwait;
    logic [31:0] iload;
    logic        iREN;
    logic [31:0] iaddr;
    logic [31:0] miss_count;

    int tests = 0;
    int fails = 0;

    logic [31:0] hit_q [$];
    logic [31:0] mem_q [$];

    icache_direct dut (
        .CLK        (CLK),
        .RST        (RST),
        .halt       (halt),
        .imemREN    (imemREN),
        .imemaddr   (imemaddr),
        .ihit       (ihit),
        .imemload   (imemload),
        .iwait      (iwait),
        .iload      (iload),
        .iREN       (iREN),
        .iaddr      (iaddr),
        .miss_count (miss_count)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Hit monitor: each cycle with ihit=1 consumes one expected data word.
    always @(negedge CLK) begin
        if (ihit === 1'b1) begin
            if (hit_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_hit: got imemload 0x%08h with nothing expected at %0t",
                         imemload, $time);
            end else begin
                check("hit_data", imemload, hit_q.pop_front());
            end
        end else begin
            check("no_hit_load_zero", imemload, 32'd0);
        end
    end

    // Memory monitor: each rising iREN consumes one expected address, and
    // that address must stay on iaddr for as long as iREN is held.
    logic        prev_iren = 1'b0;
    logic [31:0] cur_iaddr = 32'd0;
    always @(negedge CLK) begin
        if (iREN === 1'b1) begin
            if (!prev_iren) begin
                if (mem_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_iren: got iaddr 0x%08h with nothing expected at %0t",
                             iaddr, $time);
                    cur_iaddr = 32'hFFFF_FFFF;
                end else begin
                    cur_iaddr = mem_q.pop_front();
                end
            end
            check("iaddr_fetch", iaddr, cur_iaddr);
        end else begin
            check("iaddr_idle", iaddr, 32'd0);
        end
        prev_iren = (iREN === 1'b1);
    end

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    // Full miss sequence. The request is raised in cycle 0, iwait is held for
    // nwait FETCH cycles and then dropped for one cycle with the data, and a
    // hit is expected one cycle later. The request is dropped on exit.
    task automatic do_miss(input logic [31:0] addr, input logic [31:0] data,
                           input int nwait, input logic [31:0] exp_cnt);
        imemREN  = 1'b1;
        imemaddr = addr;
        iwait    = 1'b1;
        mem_q.push_back({addr[31:2], 2'b00});
        @(negedge CLK);
        check("miss_c0_ihit", ihit, 32'd0);
        check("miss_c0_count", miss_count, exp_cnt - 32'd1);
        next_cycle();
        repeat (nwait) next_cycle();
        iwait = 1'b0;
        iload = data;
        next_cycle();
        iwait = 1'b1;
        iload = 32'd0;
        hit_q.push_back(data);
        @(negedge CLK);
        check("miss_done_count", miss_count, exp_cnt);
        check("miss_done_iren", iREN, 32'd0);
        next_cycle();
        imemREN = 1'b0;
    endtask

    task automatic do_hit(input logic [31:0] addr, input logic [31:0] data);
        imemREN  = 1'b1;
        imemaddr = addr;
        hit_q.push_back(data);
        @(negedge CLK);
        check("hit_no_iren", iREN, 32'd0);
        next_cycle();
        imemREN = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        RST      = 1'b1;
        halt     = 1'b0;
        imemREN  = 1'b0;
        imemaddr = 32'd0;
        iwait    = 1'b1;
        iload    = 32'd0;

        // Outputs while reset is held.
        @(negedge CLK);
        check("rst_ihit", ihit, 32'd0);
        check("rst_iren", iREN, 32'd0);
        check("rst_count", miss_count, 32'd0);
        next_cycle();
        RST = 1'b0;

        // Cold miss with 3 wait cycles, then a hit through a misaligned address.
        do_miss(32'h0000_0040, 32'h8C22_0004, 3, 32'd1);
        do_hit(32'h0000_0042, 32'h8C22_0004);

        // Conflict in frame 0: 0x440 evicts 0x40, and 0x40 then misses again.
        do_miss(32'h0000_0440, 32'h1234_5678, 1, 32'd2);
        do_miss(32'h0000_0040, 32'h8C22_0004, 0, 32'd3);
        do_hit(32'h0000_0040, 32'h8C22_0004);

        // The address changes during FETCH, and the fill still targets 0x40.
        do_miss(32'h0000_0440, 32'h1234_5678, 0, 32'd4);
        imemREN  = 1'b1;
        imemaddr = 32'h0000_0040;
        mem_q.push_back(32'h0000_0040);
        @(negedge CLK);
        check("chg_c0_ihit", ihit, 32'd0);
        next_cycle();                      // cycle 1: FETCH 0x40
        imemaddr = 32'h0000_0080;
        next_cycle();                      // cycle 2: memory delivers
        iwait = 1'b0;
        iload = 32'hAAAA_0040;
        next_cycle();                      // cycle 3: IDLE, 0x80 misses
        iwait = 1'b1;
        iload = 32'd0;
        mem_q.push_back(32'h0000_0080);
        @(negedge CLK);
        check("chg_c3_ihit", ihit, 32'd0);
        check("chg_c3_count", miss_count, 32'd5);
        next_cycle();                      // cycle 4: FETCH 0x80, data ready
        iwait = 1'b0;
        iload = 32'hBBBB_0080;
        next_cycle();                      // cycle 5: hit on 0x80
        iwait = 1'b1;
        iload = 32'd0;
        hit_q.push_back(32'hBBBB_0080);
        @(negedge CLK);
        check("chg_c5_count", miss_count, 32'd6);
        next_cycle();
        imemREN = 1'b0;

        // Fill a different frame (idx 7) and confirm frame 0 is untouched.
        do_miss(32'h0000_001C, 32'hCAFE_F00D, 2, 32'd7);
        do_hit(32'h0000_0080, 32'hBBBB_0080);
        do_hit(32'h0000_001C, 32'hCAFE_F00D);

        // Halt on a cached address: no hit and no fill while halted.
        halt     = 1'b1;
        imemREN  = 1'b1;
        imemaddr = 32'h0000_0080;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            check("halt_ihit", ihit, 32'd0);
            check("halt_iren", iREN, 32'd0);
            next_cycle();
        end
        halt = 1'b0;
        hit_q.push_back(32'hBBBB_0080);
        @(negedge CLK);
        check("halt_release_count", miss_count, 32'd7);
        next_cycle();
        imemREN = 1'b0;

        // Reset asserted in FETCH: iREN drops at once, and the refill starts from count 0.
        imemREN  = 1'b1;
        imemaddr = 32'h0000_0024;
        iwait    = 1'b1;
        mem_q.push_back(32'h0000_0024);
        next_cycle();                      // cycle 1: FETCH
        next_cycle();                      // cycle 2: still waiting
        RST = 1'b1;
        #1;
        check("rst_fetch_iren", iREN, 32'd0);
        check("rst_fetch_iaddr", iaddr, 32'd0);
        check("rst_fetch_count", miss_count, 32'd0);
        next_cycle();
        RST = 1'b0;
        do_miss(32'h0000_0024, 32'h0BAD_C0DE, 1, 32'd1);

        next_cycle();
        next_cycle();
        check("hit_queue_drained", hit_q.size(), 32'd0);
        check("mem_queue_drained", mem_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
